// File: rtl/pipe_pkg.sv
// pipe_pkg: widths, control-word layout and immediate extension shared by the ID/EX and EX/MEM stages.
package pipe_pkg;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int IMM_W   = 16;
    localparam int ALUOP_W = 4;
    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 16;

    typedef logic [REG_W-1:0]   reg_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [ALUOP_W-1:0] aluop_t;

    // Field order is bit7..bit0 of the control word.
    typedef struct packed {
        logic zero_ext;
        logic branch;
        logic reg_dst;
        logic alu_src;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic reg_write;
    } ctrl_t;

    function automatic data_t imm_ext(input logic [IMM_W-1:0] imm, input logic zero_ext);
        return zero_ext ? {{(DATA_W-IMM_W){1'b0}}, imm} : {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/wb_bypass.sv
// wb_bypass: operand source select; $zero reads 0, a same-cycle writeback to the register wins over the file.
//   src_i      register specifier being read
//   rd_data_i  register-file read data for src_i
//   wb_we_i, wb_addr_i, wb_data_i  writeback port
//   data_o     resolved operand
module wb_bypass
    import pipe_pkg::*;
(
    input  logic  [REG_W-1:0]  src_i,
    input  logic  [DATA_W-1:0] rd_data_i,
    input  logic               wb_we_i,
    input  logic  [REG_W-1:0]  wb_addr_i,
    input  logic  [DATA_W-1:0] wb_data_i,
    output logic  [DATA_W-1:0] data_o
);
    always_comb
        data_o = (src_i == '0) ? '0 : (wb_we_i && wb_addr_i == src_i) ? wb_data_i : rd_data_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with writeback bypass, load-use stall detection and stall counter.
//   Clk, Reset (async, active low)
//   InValid, Flush, Rs/Rt/Rd, ReadData1/2, Imm, ALUOp, Ctrl  decode slot
//   WB_RegWrite, WB_WriteRegister, WB_WriteData                writeback port
//   Stall                                                      hold PC and IF/ID
//   ExValid, ExRs, ExRt, ExDestReg, ExA, ExB, ExImm, ExCtrl, ExALUOp  EX-stage register
//   StallCount                                                 saturating load-use stall cycles
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InValid,
    input  logic               Flush,
    input  logic [REG_W-1:0]   Rs,
    input  logic [REG_W-1:0]   Rt,
    input  logic [REG_W-1:0]   Rd,
    input  logic [DATA_W-1:0]  ReadData1,
    input  logic [DATA_W-1:0]  ReadData2,
    input  logic [IMM_W-1:0]   Imm,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [CTRL_W-1:0]  Ctrl,
    input  logic               WB_RegWrite,
    input  logic [REG_W-1:0]   WB_WriteRegister,
    input  logic [DATA_W-1:0]  WB_WriteData,
    output logic               Stall,
    output logic               ExValid,
    output logic [REG_W-1:0]   ExRs,
    output logic [REG_W-1:0]   ExRt,
    output logic [REG_W-1:0]   ExDestReg,
    output logic [DATA_W-1:0]  ExA,
    output logic [DATA_W-1:0]  ExB,
    output logic [DATA_W-1:0]  ExImm,
    output logic [CTRL_W-1:0]  ExCtrl,
    output logic [ALUOP_W-1:0] ExALUOp,
    output logic [CNT_W-1:0]   StallCount
);
    ctrl_t  in_ctrl, ctrl_q, ctrl_d;
    logic   valid_q, valid_d, bubble;
    reg_t   rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    data_t  a_q, a_d, b_q, b_d, imm_q, imm_d, src_a, src_b;
    aluop_t op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_ctrl = ctrl_t'(Ctrl);

    wb_bypass u_byp_a (
        .src_i(Rs), .rd_data_i(ReadData1), .wb_we_i(WB_RegWrite),
        .wb_addr_i(WB_WriteRegister), .wb_data_i(WB_WriteData), .data_o(src_a)
    );

    wb_bypass u_byp_b (
        .src_i(Rt), .rd_data_i(ReadData2), .wb_we_i(WB_RegWrite),
        .wb_addr_i(WB_WriteRegister), .wb_data_i(WB_WriteData), .data_o(src_b)
    );

    // The bubble clears mem_read in EX, so the stall self-terminates after one cycle.
    assign Stall  = InValid & ~Flush & valid_q & ctrl_q.mem_read & (rt_q != '0) & (rt_q == Rs | rt_q == Rt);
    assign bubble = Flush | Stall;

    always_comb begin
        valid_d = bubble ? 1'b0 : InValid;
        ctrl_d  = (bubble || !InValid) ? '0 : in_ctrl;
        a_d     = bubble ? a_q : src_a;
        b_d     = bubble ? b_q : src_b;
        imm_d   = bubble ? imm_q : imm_ext(Imm, in_ctrl.zero_ext);
        rs_d    = bubble ? rs_q : Rs;
        rt_d    = bubble ? rt_q : Rt;
        dest_d  = bubble ? dest_q : (in_ctrl.reg_dst ? Rd : Rt);
        op_d    = bubble ? op_q : ALUOp;
        cnt_d   = (Stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dest_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            dest_q  <= dest_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ExValid    = valid_q;
    assign ExCtrl     = ctrl_q;
    assign ExA        = a_q;
    assign ExB        = b_q;
    assign ExImm      = imm_q;
    assign ExRs       = rs_q;
    assign ExRt       = rt_q;
    assign ExDestReg  = dest_q;
    assign ExALUOp    = op_q;
    assign StallCount = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    logic        Clk = 1'b0, Reset = 1'b0, InValid = 1'b0, Flush = 1'b0;
    logic [4:0]  Rs = '0, Rt = '0, Rd = '0, WB_WriteRegister = '0;
    logic [31:0] ReadData1 = '0, ReadData2 = '0, WB_WriteData = '0;
    logic [15:0] Imm = '0;
    logic [3:0]  ALUOp = '0;
    logic [7:0]  Ctrl = '0;
    logic        WB_RegWrite = 1'b0;
    logic        Stall, ExValid;
    logic [4:0]  ExRs, ExRt, ExDestReg;
    logic [31:0] ExA, ExB, ExImm;
    logic [7:0]  ExCtrl;
    logic [3:0]  ExALUOp;
    logic [15:0] StallCount;
    int n_chk = 0, n_fail = 0;

    id_ex_stage dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .Flush(Flush),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Imm(Imm), .ALUOp(ALUOp), .Ctrl(Ctrl),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData),
        .Stall(Stall), .ExValid(ExValid), .ExRs(ExRs), .ExRt(ExRt), .ExDestReg(ExDestReg),
        .ExA(ExA), .ExB(ExB), .ExImm(ExImm), .ExCtrl(ExCtrl), .ExALUOp(ExALUOp),
        .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ExValid"}, {31'b0, ExValid}, 0);
        chk({tag, " ExCtrl"}, {24'b0, ExCtrl}, 0);
        chk({tag, " ExALUOp"}, {28'b0, ExALUOp}, 0);
        chk({tag, " ExRs"}, {27'b0, ExRs}, 0);
        chk({tag, " ExRt"}, {27'b0, ExRt}, 0);
        chk({tag, " ExDestReg"}, {27'b0, ExDestReg}, 0);
        chk({tag, " ExA"}, ExA, 0);
        chk({tag, " ExB"}, ExB, 0);
        chk({tag, " ExImm"}, ExImm, 0);
        chk({tag, " StallCount"}, {16'b0, StallCount}, 0);
    endtask

    task automatic load_into_ex();
        InValid = 1; Flush = 0; Ctrl = 8'h13; Rs = 5'd1; Rt = 5'd9; Rd = 5'd0;
        ReadData1 = 32'h1234; ReadData2 = 32'h0; WB_RegWrite = 0; ALUOp = 4'd2; Imm = 16'h0004;
        tick();
        chk("load ExCtrl", {24'b0, ExCtrl}, 32'h13);
        chk("load ExRt", {27'b0, ExRt}, 9);
        Rs = 5'd9; Rt = 5'd3; Ctrl = 8'h01; ALUOp = 4'd5; ReadData1 = 32'h99; ReadData2 = 32'h33;
        #1;
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        #1 Reset = 1;
        // basic capture with writeback bypass on A
        InValid = 1; Rs = 5'd8; Rt = 5'd2; Rd = 5'd4; ReadData1 = 32'h11; ReadData2 = 32'h22;
        WB_RegWrite = 1; WB_WriteRegister = 5'd8; WB_WriteData = 32'hABCD;
        Ctrl = 8'h01; ALUOp = 4'd3; Imm = 16'h0010;
        tick();
        chk("byp ExA", ExA, 32'hABCD);
        chk("byp ExB", ExB, 32'h22);
        chk("byp ExValid", {31'b0, ExValid}, 1);
        chk("byp ExCtrl", {24'b0, ExCtrl}, 32'h01);
        chk("byp ExDestReg rt", {27'b0, ExDestReg}, 2);
        chk("byp ExALUOp", {28'b0, ExALUOp}, 3);
        chk("byp ExImm", ExImm, 32'h10);
        chk("byp Stall", {31'b0, Stall}, 0);
        // no writeback -> register file data; RegDst selects Rd
        WB_RegWrite = 0; Ctrl = 8'h21;
        tick();
        chk("nobyp ExA", ExA, 32'h11);
        chk("regdst ExDestReg", {27'b0, ExDestReg}, 4);
        // $zero never bypassed
        Rs = 5'd0; ReadData1 = 32'h5; WB_RegWrite = 1; WB_WriteRegister = 5'd0; WB_WriteData = 32'h7;
        tick();
        chk("zero ExA", ExA, 32'h0);
        chk("zero ExB", ExB, 32'h22);
        // both operands bypassed
        Rs = 5'd6; Rt = 5'd6; ReadData1 = 32'h1; ReadData2 = 32'h2; WB_WriteRegister = 5'd6; WB_WriteData = 32'h55;
        tick();
        chk("dual ExA", ExA, 32'h55);
        chk("dual ExB", ExB, 32'h55);
        // immediate extension
        WB_RegWrite = 0; Imm = 16'h8000; Ctrl = 8'h01;
        tick();
        chk("sext ExImm", ExImm, 32'hFFFF8000);
        Ctrl = 8'h81;
        tick();
        chk("zext ExImm", ExImm, 32'h00008000);
        // invalid slot captures a null instruction
        InValid = 0; Ctrl = 8'hFF;
        tick();
        chk("inv ExValid", {31'b0, ExValid}, 0);
        chk("inv ExCtrl", {24'b0, ExCtrl}, 0);
        // load-use: one stall cycle, bubble, then capture
        load_into_ex();
        chk("lu Stall", {31'b0, Stall}, 1);
        tick();
        chk("lu bubble ExValid", {31'b0, ExValid}, 0);
        chk("lu bubble ExCtrl", {24'b0, ExCtrl}, 0);
        chk("lu bubble ExA hold", ExA, 32'h1234);
        chk("lu StallCount", {16'b0, StallCount}, 1);
        chk("lu Stall drop", {31'b0, Stall}, 0);
        tick();
        chk("lu cap ExValid", {31'b0, ExValid}, 1);
        chk("lu cap ExA", ExA, 32'h99);
        chk("lu cap ExRs", {27'b0, ExRs}, 9);
        chk("lu cap ExALUOp", {28'b0, ExALUOp}, 5);
        chk("lu cap StallCount", {16'b0, StallCount}, 1);
        // load-use with flush: no stall, bubble, counter unchanged
        load_into_ex();
        Flush = 1;
        #1;
        chk("fl Stall", {31'b0, Stall}, 0);
        tick();
        chk("fl ExValid", {31'b0, ExValid}, 0);
        chk("fl ExCtrl", {24'b0, ExCtrl}, 0);
        chk("fl StallCount", {16'b0, StallCount}, 1);
        // reset asserted mid-stall clears everything without a clock edge
        load_into_ex();
        chk("rst pre Stall", {31'b0, Stall}, 1);
        Reset = 0;
        #1;
        chk("rst Stall", {31'b0, Stall}, 0);
        chk_all_zero("async reset");
        #1 Reset = 1;
        tick();
        chk("post rst ExValid", {31'b0, ExValid}, 1);
        chk("post rst ExA", ExA, 32'h99);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port Clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port InValid  input  1  decode slot holds a real instruction.
REQ-004 SHALL have port Flush  input  1  squash decode instruction (taken branch/jump).
REQ-005 SHALL have ports Rs, Rt, Rd  input  5 each  decoded register specifiers.
REQ-006 SHALL have ports ReadData1, ReadData2  input  32 each  RegisterFile read data for Rs/Rt.
REQ-007 SHALL have ports Imm  input  16 (immediate) and ALUOp  input  4.
REQ-008 SHALL have port Ctrl  input  8  {ZeroExt,Branch,RegDst,ALUSrc,MemToReg,MemWrite,MemRead,RegWrite}, bit7..bit0.
REQ-009 SHALL have ports WB_RegWrite  input  1, WB_WriteRegister  input  5, WB_WriteData  input  32  (writeback port, same values driven into RegisterFile).
REQ-010 SHALL have port Stall  output  1  hold PC and IF/ID this cycle.
REQ-011 SHALL have ports ExValid  output  1, ExRs/ExRt/ExDestReg  output  5, ExA/ExB/ExImm  output  32, ExCtrl  output  8, ExALUOp  output  4.
REQ-012 SHALL have port StallCount  output  16  saturating count of load-use stall cycles.

Function
REQ-013 Bypass: SrcA SHALL be 0 if Rs==0; else WB_WriteData if WB_RegWrite and WB_WriteRegister==Rs; else ReadData1; SrcB likewise with Rt/ReadData2.
REQ-014 ImmExt SHALL be {16'b0,Imm} when Ctrl[7]=1, else {16{Imm[15]},Imm}.
REQ-015 DestReg SHALL be Rd when Ctrl[5]=1, else Rt.
REQ-016 Stall SHALL be combinational: InValid & ~Flush & ExValid & ExCtrl[1] & ExRt!=0 & (ExRt==Rs | ExRt==Rt).
REQ-017 Each rising Clk, priority Flush > Stall > capture: Flush or Stall SHALL load ExValid=0, ExCtrl=0 (bubble), other Ex* fields hold.
REQ-018 Capture SHALL load ExValid=InValid, ExCtrl=InValid?Ctrl:0, ExA=SrcA, ExB=SrcB, ExImm=ImmExt, ExRs=Rs, ExRt=Rt, ExDestReg=DestReg, ExALUOp=ALUOp; latency one cycle.
REQ-019 StallCount SHALL increment by 1 on each rising Clk where Stall=1, saturating at 16'hFFFF.
REQ-020 Stall SHALL deassert the cycle after a bubble is inserted (bubble has ExCtrl[1]=0), giving exactly one stall cycle per load-use.
REQ-021 Simultaneous WB write to Rs and Rt SHALL bypass both operands.

Reset
REQ-022 Reset low SHALL immediately clear ExValid, ExCtrl, ExALUOp, ExRs, ExRt, ExDestReg, ExA, ExB, ExImm, StallCount to 0, independent of Clk.
REQ-023 Reset asserted mid-stall SHALL drop Stall to 0 at once (ExValid=0).
REQ-024 First capture SHALL occur on the first rising Clk after Reset returns high.

Structure
REQ-025 Ctrl bit indices, ALUOp width, and register/data widths SHALL live in shared package pipe_pkg, reused by the EX/MEM stage.
REQ-026 Bypass muxing of REQ-013 SHALL be sub-module wb_bypass, instantiated twice (A and B).

Verification
REQ-027 Reset low at t=5 with outputs nonzero -> all Ex* and StallCount 0 before next Clk edge.
REQ-028 Rs=8, ReadData1=0x11, WB_RegWrite=1, WB_WriteRegister=8, WB_WriteData=0xABCD -> ExA=0xABCD after one edge; with WB_RegWrite=0 -> ExA=0x11.
REQ-029 Load (Ctrl=0x13, Rt=9) captured, next instr Rs=9 -> Stall=1 one cycle, ExValid=0 bubble, StallCount=1, then instr captured with Stall=0.
REQ-030 Same load-use as REQ-029 with Flush=1 -> Stall=0, bubble inserted, StallCount unchanged.
REQ-031 Imm=0x8000, Ctrl[7]=0 -> ExImm=0xFFFF8000; Ctrl[7]=1 -> ExImm=0x00008000.
REQ-032 Rs=0, ReadData1=0x5, WB writing reg 0 with 0x7 -> ExA=0.
